rr_grant_scheduler4: RTL

//  Round-robin scheduler sharing one resource among 4 requesters. Picks a winner

---
 rtl/rr_grant_scheduler4_pkg.sv | 13 +
 rtl/rr_grant_scheduler4_dec.sv | 24 ++
 rtl/rr_grant_scheduler4.sv | 131 +++++++++++++
 3 files changed

// File: rtl/rr_grant_scheduler4_pkg.sv
// Shared types and constants for the 4-way round-robin grant scheduler.
// Defines requester count, index width and the IDLE/GRANT state encoding.
package rr_grant_scheduler4_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_grant_scheduler4_dec.sv
// Behavioural 2-to-4 decoder: one-hot out[address] when enable, else 0.
// Ports: address (index), enable (active-high), out (one-hot, NREQ wide).
module rr_grant_scheduler4_dec
  import rr_grant_scheduler4_pkg::*;
(
  input  logic [IDX_W-1:0] address,
  input  logic             enable,
  output logic [NREQ-1:0]  out
);

  always_comb begin
    out = '0;
    if (enable) begin
      unique case (address)
        2'd0: out = 4'b0001;
        2'd1: out = 4'b0010;
        2'd2: out = 4'b0100;
        2'd3: out = 4'b1000;
        default: out = '0;
      endcase
    end
  end

endmodule

// File: rtl/rr_grant_scheduler4.sv
// Round-robin scheduler granting one shared resource among 4 requesters.
// Ports: clk, reset (sync, active-high), req[3:0], done (owner release),
//   gnt[3:0] one-hot, gnt_valid, gnt_id[1:0], timeout (forced-release pulse).
// Optional macro ARB_TIMEOUT_EN: force release after MAX_HOLD grant cycles.
module rr_grant_scheduler4
  import rr_grant_scheduler4_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [NREQ-1:0]  gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_id,
  output logic             timeout
);

  if (2**CNT_W <= MAX_HOLD) begin : g_bad_cfg
    $error("CNT_W too narrow for MAX_HOLD");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] gnt_id_q, gnt_id_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] scan_idx;
  logic             found;
  logic             release_req;

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Scan starts just after the last owner so it ends up lowest priority.
  always_comb begin
    winner   = last_q;
    found    = 1'b0;
    scan_idx = last_q;
    for (int i = 1; i <= NREQ; i++) begin
      scan_idx = last_q + IDX_W'(i);
      if (!found && req[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  assign release_req = done | ~req[gnt_id_q];

  always_comb begin
    state_d  = state_q;
    gnt_id_d = gnt_id_q;
    last_d   = last_q;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d  = ST_GRANT;
          gnt_id_d = winner;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (release_req) begin
          state_d = ST_IDLE;
          last_d  = gnt_id_q;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt_q == HOLD_LAST) begin
          state_d   = ST_IDLE;
          last_d    = gnt_id_q;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      gnt_id_q <= 2'd3;
      last_q   <= 2'd3;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      last_q   <= last_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt_valid = (state_q == ST_GRANT);
  assign gnt_id    = gnt_id_q;

  rr_grant_scheduler4_dec u_gnt_dec (
    .address (gnt_id_q),
    .enable  (gnt_valid),
    .out     (gnt)
  );

endmodule
